// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared data-bus types, access-size encoding and lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_HOLD      = 2'd3
    } mau_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    function automatic logic [3:0] strobe_of(input msize_t size, input logic [1:0] addr);
        case (size)
            MSIZE1:  return 4'b0001 << addr;
            MSIZE2:  return 4'b0011 << addr;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align_addr(input msize_t size, input logic [31:0] addr);
        case (size)
            MSIZE1:  return addr;
            MSIZE2:  return {addr[31:1], 1'b0};
            default: return {addr[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic misaligned(input msize_t size, input logic [1:0] addr);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return addr[0];
            default: return |addr;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input msize_t size, input logic [31:0] wdata);
        case (size)
            MSIZE1:  return {4{wdata[7:0]}};
            MSIZE2:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Selects the addressed byte/half/word of a bus word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_offset,
    input  msize_t      i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_raw >> {i_offset, 3'b000};
        case (i_size)
            MSIZE1:  o_result = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
            MSIZE2:  o_result = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : M-stage load/store engine on the addr_ok/data_ok dbus.
//               Optional misalignment exception: MEM_ACCESS_UNIT_ALIGN_EXC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] RESET_PC_TAG = 32'hbfc0_0000,
    parameter int          MAX_WAIT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  msize_t      req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        pipe_advance,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        bus_timeout,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
    ,
    output logic        addr_err,
    output logic [31:0] bad_vaddr
`endif
);

    localparam int                c_cw  = $clog2(MAX_WAIT) + 1;
    localparam logic [c_cw-1:0]   c_one = c_cw'(1);
    localparam logic [c_cw-1:0]   c_max = c_cw'(MAX_WAIT);

    mau_state_t      r_state;
    dbus_req_t       r_dreq;
    logic            r_signed;
    logic            r_write;
    logic            r_done;
    logic [31:0]     r_rdata;
    logic            r_timeout;
    logic [c_cw-1:0] r_wait_cnt;
    logic [31:0]     r_dbg_tag;

    logic            w_start;
    logic [31:0]     w_addr_al;
    dbus_req_t       w_new_req;
    logic [31:0]     w_load;
    logic            w_unused_dbg;

`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
    logic            r_addr_err;
    logic [31:0]     r_bad_vaddr;
    logic            w_misalign;

    assign w_misalign = misaligned(req_size, req_addr[1:0]);
    assign addr_err   = r_addr_err;
    assign bad_vaddr  = r_bad_vaddr;
`endif

    // A new access may begin from IDLE, or straight out of HOLD when the pipe moves.
    assign w_start   = req_valid && ((r_state == S_IDLE) || ((r_state == S_HOLD) && pipe_advance));
    assign w_addr_al = align_addr(req_size, req_addr);

    always_comb begin
        w_new_req       = '0;
        w_new_req.valid = 1'b1;
        w_new_req.addr  = w_addr_al;
        w_new_req.size  = req_size;
        if (req_write) begin
            w_new_req.strobe = strobe_of(req_size, w_addr_al[1:0]);
            w_new_req.data   = replicate(req_size, req_wdata);
        end
    end

    load_extender u_load_extender (
        .i_raw    (dresp.data),
        .i_offset (r_dreq.addr[1:0]),
        .i_size   (r_dreq.size),
        .i_signed (r_signed),
        .o_result (w_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dreq     <= '0;
            r_signed   <= 1'b0;
            r_write    <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
            r_dbg_tag  <= RESET_PC_TAG;
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
            r_addr_err  <= 1'b0;
            r_bad_vaddr <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (dresp.addr_ok) begin
                        r_dreq.valid <= 1'b0;
                        if (dresp.data_ok) begin
                            r_state <= S_HOLD;
                            r_done  <= 1'b1;
                            r_rdata <= r_write ? 32'd0 : w_load;
                        end else begin
                            r_state    <= S_WAIT_DATA;
                            r_wait_cnt <= c_one;
                            r_timeout  <= (c_one == c_max);
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (dresp.data_ok) begin
                        r_state    <= S_HOLD;
                        r_done     <= 1'b1;
                        r_rdata    <= r_write ? 32'd0 : w_load;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != c_max) begin
                        // Pulse only on the step into saturation, never while parked there.
                        r_wait_cnt <= r_wait_cnt + c_one;
                        r_timeout  <= ((r_wait_cnt + c_one) == c_max);
                    end
                end
                S_HOLD: begin
                    if (pipe_advance) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
                        r_addr_err <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase

            // Later assignments take priority over the HOLD exit above.
            if (w_start) begin
                r_dbg_tag <= req_addr;
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
                if (w_misalign) begin
                    r_state     <= S_HOLD;
                    r_done      <= 1'b1;
                    r_rdata     <= '0;
                    r_addr_err  <= 1'b1;
                    r_bad_vaddr <= req_addr;
                end else
`endif
                begin
                    r_state  <= S_REQ;
                    r_dreq   <= w_new_req;
                    r_signed <= req_signed;
                    r_write  <= req_write;
                end
            end
        end
    end

    assign stall = (r_state == S_REQ) || (r_state == S_WAIT_DATA) ||
                   ((r_state == S_IDLE) && req_valid);
    assign dreq        = r_dreq;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign bus_timeout = r_timeout;

    // Debug tag has no functional consumer.
    assign w_unused_dbg = ^r_dbg_tag;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed and randomized bench for mem_access_unit with a lane model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_write, req_signed, pipe_advance;
    msize_t      req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, bus_timeout;
    logic [31:0] rdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
    logic        addr_err;
    logic [31:0] bad_vaddr;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp;
    logic        last_is_load;
    logic        in_hold;

    always #5 clk = ~clk;

    mem_access_unit #(.RESET_PC_TAG(32'hbfc0_0000), .MAX_WAIT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .pipe_advance (pipe_advance),
        .stall        (stall),
        .rdata        (rdata),
        .done         (done),
        .bus_timeout  (bus_timeout),
        .dreq         (dreq),
        .dresp        (dresp)
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
        ,
        .addr_err     (addr_err),
        .bad_vaddr    (bad_vaddr)
`endif
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic.
    function automatic int nbytes(input msize_t s);
        return (s == MSIZE1) ? 1 : (s == MSIZE2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input msize_t s);
        return a - (a % nbytes(s));
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [31:0] a, input msize_t s, input logic wr);
        logic [3:0] st;
        int lo;
        st = 4'h0;
        lo = int'(eff_addr(a, s) % 4);
        if (wr)
            for (int i = 0; i < 4; i++)
                if (i >= lo && i < lo + nbytes(s)) st[i] = 1'b1;
        return st;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] w, input msize_t s);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                             input msize_t s, input logic sg);
        longint v, m;
        int lo;
        lo = int'(eff_addr(a, s) % 4);
        v  = longint'(word >> (8 * lo));
        if (nbytes(s) == 4) return v[31:0];
        m = longint'(1) << (8 * nbytes(s));
        v = v % m;
        if (sg && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    // Presents a request at the current negedge and runs it to the HOLD cycle.
    task automatic issue(input logic wr, input msize_t sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mem, input int adly,
                         input int wdly, input logic from_hold);
        int stalls;
        stalls = 0;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; pipe_advance = from_hold; dresp = '0;
        #1 check("stall_at_request", stall, !from_hold);
        @(negedge clk);
        pipe_advance = 1'b0;
        for (int c = 0; c <= adly; c++) begin
            check("req_valid", dreq.valid, 1'b1);
            check("req_addr", dreq.addr, eff_addr(a, sz));
            check("req_size", dreq.size, sz);
            check("req_strobe", dreq.strobe, exp_strobe(a, sz, wr));
            if (wr) check("req_wdata", dreq.data, exp_wdata(wd, sz));
            stalls += int'(stall);
            dresp.addr_ok = (c == adly);
            dresp.data_ok = (c == adly) && (wdly == 0);
            dresp.data    = mem;
            @(negedge clk);
        end
        for (int k = 1; k <= wdly; k++) begin
            check("wait_valid_low", dreq.valid, 1'b0);
            check("wait_done_low", done, 1'b0);
            stalls += int'(stall);
            dresp.addr_ok = 1'b0;
            dresp.data_ok = (k == wdly);
            dresp.data    = mem;
            @(negedge clk);
        end
        dresp.addr_ok = 1'b0; dresp.data_ok = 1'b0; dresp.data = $urandom;
        check("done_set", done, 1'b1);
        stalls += int'(stall);
        check("stall_cycles", stalls, adly + 1 + wdly);
        last_is_load = !wr;
        last_exp     = exp_load(mem, a, sz, sg);
        if (!wr) check("load_rdata", rdata, last_exp);
    endtask

    // Lingers in HOLD (with stray bus responses), then lets the pipe advance.
    task automatic retire(input int holds);
        for (int h = 0; h < holds; h++) begin
            pipe_advance = 1'b0;
            dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = $urandom;
            @(negedge clk);
            check("hold_done", done, 1'b1);
            check("hold_stall", stall, 1'b0);
            if (last_is_load) check("hold_rdata", rdata, last_exp);
        end
        dresp = '0; pipe_advance = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        pipe_advance = 1'b0;
        check("retire_done", done, 1'b0);
        check("retire_stall", stall, 1'b0);
        check("retire_valid", dreq.valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = MSIZE1; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; pipe_advance = 1'b0; dresp = '0;
        last_exp = '0; last_is_load = 1'b0; in_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_dreq", dreq, 96'd0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_timeout", bus_timeout, 1'b0);

        // Zero-wait word store
        issue(1'b1, MSIZE4, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
        retire(0);
        // Signed byte load with three-cycle data delay
        issue(1'b0, MSIZE1, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 0, 3, 1'b0);
        check("byte_load_vec", rdata, 32'hFFFF_FF80);
        retire(1);
        // Half store then half load, then a back-to-back word load
        issue(1'b1, MSIZE2, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
        retire(0);
        issue(1'b0, MSIZE2, 1'b0, 32'h202, 32'h0, 32'hBEEF_0000, 1, 0, 1'b0);
        check("half_load_vec", rdata, 32'h0000_BEEF);
        issue(1'b0, MSIZE4, 1'b0, 32'h204, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b1);
        retire(0);

        // Data never arrives: timeout pulse, then reset mid-transaction
        req_valid = 1'b1; req_write = 1'b0; req_size = MSIZE4; req_signed = 1'b0;
        req_addr = 32'h300; dresp = '0;
        @(negedge clk);
        check("to_req_valid", dreq.valid, 1'b1);
        dresp.addr_ok = 1'b1;
        @(negedge clk);
        dresp = '0;
        for (int k = 1; k <= 20; k++) begin
            check("timeout_pulse", bus_timeout, (k == 16));
            check("timeout_stall", stall, 1'b1);
            if (k < 20) @(negedge clk);
        end
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 32'h1234_5678;
        check("rst_mid_dreq", dreq, 96'd0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_stall", stall, 1'b0);
        @(negedge clk);
        dresp = '0;
        check("late_data_done", done, 1'b0);
        check("late_data_rdata", rdata, 32'd0);
        check("late_data_dreq", dreq, 96'd0);

`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
        req_valid = 1'b1; req_write = 1'b0; req_size = MSIZE4; req_addr = 32'h101;
        #1 check("misalign_stall", stall, 1'b1);
        @(negedge clk);
        check("misalign_valid", dreq.valid, 1'b0);
        check("misalign_done", done, 1'b1);
        check("misalign_err", addr_err, 1'b1);
        check("misalign_vaddr", bad_vaddr, 32'h101);
        check("misalign_rdata", rdata, 32'd0);
        pipe_advance = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        pipe_advance = 1'b0;
        check("misalign_clear", addr_err, 1'b0);
        check("misalign_done_clr", done, 1'b0);
`endif

        // Randomized accesses against the lane model
        for (int i = 0; i < 40; i++) begin
            logic        wr, sg;
            msize_t      sz;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = msize_t'($urandom_range(0, 2));
            a  = $urandom;
`ifdef MEM_ACCESS_UNIT_ALIGN_EXC_EN
            a  = eff_addr(a, sz);
`endif
            issue(wr, sz, sg, a, $urandom, $urandom, $urandom_range(0, 2),
                  $urandom_range(0, 3), in_hold);
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
            end else begin
                retire($urandom_range(0, 2));
                in_hold = 1'b0;
            end
        end
        if (in_hold) retire(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
